// File: rtl/msdf_add_scheduler.sv
// Round-robin front end for a single shared MSDF online adder.
// Grants one requester, clears the adder, streams digits MSD-first and returns the result.
module msdf_add_scheduler #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned NDIG     = 8,
  parameter int unsigned DELTA    = 2,
  parameter logic [1:0]  ZERO_DIG = 2'b00,
  localparam int unsigned IDW     = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int unsigned KW      = $clog2(NDIG + DELTA + 1),
  localparam int unsigned RW      = 2 * (NDIG + DELTA)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*2*NDIG-1:0] req_a,
  input  logic [NREQ*2*NDIG-1:0] req_b,
  output logic                   adder_rst,
  output logic                   adder_start,
  output logic [1:0]             adder_a,
  output logic [1:0]             adder_b,
  input  logic [1:0]             adder_c,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [RW-1:0]          rsp_data,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, CLR, RUN, RESP} state_e;

  localparam logic [KW-1:0] KMAX = KW'(NDIG + DELTA);
  localparam logic [KW-1:0] KDIG = KW'(NDIG);

  state_e            state_q, state_d;
  logic [IDW-1:0]    rr_q, rr_d;
  logic [IDW-1:0]    id_q, id_d;
  logic [KW-1:0]     k_q, k_d;
  logic [2*NDIG-1:0] a_q, a_d, b_q, b_d;
  logic [RW-1:0]     res_q, res_d;

  logic              found;
  logic [IDW-1:0]    win, cand;
  logic [2*NDIG-1:0] sel_a, sel_b;

  // First valid requester at or after rr, wrapping around.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = IDW'((rr_q + i) % NREQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win == IDW'(i)) begin
        sel_a = req_a[i*2*NDIG +: 2*NDIG];
        sel_b = req_b[i*2*NDIG +: 2*NDIG];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      rr_q    <= '0;
      id_q    <= '0;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = CLR;
          id_d    = win;
          a_d     = sel_a;
          b_d     = sel_b;
          rr_d    = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
        end
      end
      CLR: begin
        state_d = RUN;
        k_d     = '0;
      end
      RUN: begin
        // Operands shift left so the current digit is always in the top two bits.
        a_d = a_q << 2;
        b_d = b_q << 2;
        if (k_q != '0) res_d = {res_q[RW-3:0], adder_c};
        if (k_q == KMAX) state_d = RESP;
        else             k_d     = k_q + 1'b1;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready   = '0;
    adder_start = 1'b0;
    adder_a     = ZERO_DIG;
    adder_b     = ZERO_DIG;
    rsp_valid   = 1'b0;
    busy        = (state_q != IDLE);
    adder_rst   = !reset || (state_q == CLR);
    unique case (state_q)
      IDLE: begin
        if (reset && found) req_ready[win] = 1'b1;
      end
      RUN: begin
        adder_start = (k_q == '0);
        if (k_q < KDIG) begin
          adder_a = a_q[2*NDIG-1 -: 2];
          adder_b = b_q[2*NDIG-1 -: 2];
        end
      end
      RESP: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign rsp_id   = id_q;
  assign rsp_data = res_q;

endmodule

// File: tb/tb_msdf_add_scheduler.sv
// Bench for msdf_add_scheduler: stand-in online adder, phase-based reference model,
// per-cycle comparison and directed scenarios with literal expectations.
module tb_msdf_add_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid, req_ready;
  logic [63:0] req_a, req_b;
  logic        adder_rst, adder_start;
  logic [1:0]  adder_a, adder_b, adder_c;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_id;
  logic [19:0] rsp_data;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  msdf_add_scheduler #(.NREQ(4), .NDIG(8), .DELTA(2), .ZERO_DIG(2'b00)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .adder_rst(adder_rst), .adder_start(adder_start),
    .adder_a(adder_a), .adder_b(adder_b), .adder_c(adder_c), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  // Stand-in adder with two cycles of latency and internal state cleared by adder_rst.
  logic [1:0] s1, s2, acc;
  always @(posedge clk) begin
    if (adder_rst) begin
      s1 <= 2'b00; s2 <= 2'b00; acc <= 2'b00;
    end else begin
      s1  <= adder_a ^ adder_b ^ acc ^ (adder_start ? 2'b11 : 2'b00);
      s2  <= s1;
      acc <= acc + adder_a;
    end
  end
  assign adder_c = s2;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] dig(input logic [15:0] x, input int k);
    if (k < 8) return x[15-2*k -: 2];
    return 2'b00;
  endfunction

  // Result digits: captures at k=1..10 of adder output, which lags its input by two cycles.
  function automatic logic [19:0] exp_result(input logic [15:0] a, input logic [15:0] b);
    logic [1:0] ac, ak, bk;
    logic [1:0] g [0:8];
    logic [19:0] r;
    ac = 2'b00;
    r  = '0;
    for (int k = 0; k <= 8; k++) begin
      ak = dig(a, k);
      bk = dig(b, k);
      g[k] = ak ^ bk ^ ac ^ ((k == 0) ? 2'b11 : 2'b00);
      ac = ac + ak;
    end
    for (int j = 1; j <= 10; j++) r = {r[17:0], (j >= 2) ? g[j-2] : 2'b00};
    return r;
  endfunction

  function automatic logic [3:0] arb(input logic [3:0] v, input logic [1:0] rr);
    logic [1:0] j;
    arb = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      j = rr + 2'(i);
      if (v[j] && arb == 4'b0000) arb[j] = 1'b1;
    end
  endfunction

  function automatic logic [1:0] oh_id(input logic [3:0] oh);
    case (oh)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Reference model: phase = cycles since grant (0 idle, 1 clear, 2..12 stream, 13 response).
  int          cyc = 0;
  int          m_phase = 0;
  logic [1:0]  m_rr = 2'd0, m_id = 2'd0;
  logic [15:0] m_a = '0, m_b = '0;
  logic [3:0]  m_g;

  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      m_phase = 0;
      m_rr    = 2'd0;
    end else if (m_phase == 0) begin
      m_g = arb(req_valid, m_rr);
      if (m_g != 4'b0000) begin
        m_id    = oh_id(m_g);
        m_a     = 16'(req_a >> (32'(m_id) * 16));
        m_b     = 16'(req_b >> (32'(m_id) * 16));
        m_rr    = m_id + 2'd1;
        m_phase = 1;
      end
    end else if (m_phase < 13) begin
      m_phase++;
    end else if (rsp_ready) begin
      m_phase = 0;
    end
  end

  int         gq_cyc[$];
  logic [3:0] gq_oh[$];

  always @(negedge clk) begin
    if (!reset) begin
      check("adder_rst_in_reset", 32'(adder_rst), 32'd1);
      check("req_ready_in_reset", 32'(req_ready), 32'd0);
    end else begin
      if ((req_ready & req_valid) != 4'b0000) begin
        gq_cyc.push_back(cyc);
        gq_oh.push_back(req_ready);
      end
      check("req_ready", 32'(req_ready), 32'((m_phase == 0) ? arb(req_valid, m_rr) : 4'b0000));
      check("busy", 32'(busy), 32'(m_phase != 0));
      check("adder_rst", 32'(adder_rst), 32'(m_phase == 1));
      check("adder_start", 32'(adder_start), 32'(m_phase == 2));
      check("adder_a", 32'(adder_a), 32'((m_phase >= 2 && m_phase < 10) ? dig(m_a, m_phase - 2) : 2'b00));
      check("adder_b", 32'(adder_b), 32'((m_phase >= 2 && m_phase < 10) ? dig(m_b, m_phase - 2) : 2'b00));
      check("rsp_valid", 32'(rsp_valid), 32'(m_phase == 13));
      if (m_phase == 13) begin
        check("rsp_id", 32'(rsp_id), 32'(m_id));
        check("rsp_data", 32'(rsp_data), 32'(exp_result(m_a, m_b)));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    tick;
    tick;
    reset = 1'b1;
  endtask

  task automatic wait_grants(input int n);
    for (int i = 0; i < 400 && gq_oh.size() < n; i++) sample;
    check("grant_count", 32'(gq_oh.size()), 32'(n));
  endtask

  task automatic wait_rsp(input logic [1:0] id);
    for (int i = 0; i < 100 && !rsp_valid; i++) sample;
    check("rsp_seen", 32'(rsp_valid), 32'd1);
    check("rsp_id_lit", 32'(rsp_id), 32'(id));
  endtask

  logic [3:0] exp_oh [0:4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; req_valid = 4'b0000; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    tick;
    tick;
    sample;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_adder_start", 32'(adder_start), 32'd0);
    check("rst_adder_a", 32'(adder_a), 32'd0);

    // Single op on requester 2: A = all +1, B = zero.
    tick;
    reset = 1'b1;
    req_valid = 4'b0100;
    req_a = 64'h0000_5555_0000_0000;
    req_b = '0;
    gq_oh.delete(); gq_cyc.delete();
    wait_grants(1);
    check("t1_grant", 32'(req_ready), 32'b0100);
    tick;
    req_valid = 4'b0000; req_a = '1; req_b = '1;
    for (int t = 1; t <= 13; t++) begin
      sample;
      if (t < 13) begin
        check("t1_adder_rst", 32'(adder_rst), 32'(t == 1));
        check("t1_adder_start", 32'(adder_start), 32'(t == 2));
        check("t1_adder_a", 32'(adder_a), (t >= 2 && t <= 9) ? 32'd1 : 32'd0);
        check("t1_rsp_valid_low", 32'(rsp_valid), 32'd0);
      end else begin
        check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        check("t1_rsp_id", 32'(rsp_id), 32'd2);
        check("t1_rsp_data", 32'(rsp_data), 32'h23938);
      end
    end

    // All four requesters continuously valid.
    tick;
    do_reset;
    req_a = 64'h1234_5678_9abc_def0;
    req_b = 64'h0f0f_3c3c_a5a5_7e81;
    req_valid = 4'b1111;
    gq_oh.delete(); gq_cyc.delete();
    wait_grants(5);
    tick;
    req_valid = 4'b0000;
    for (int i = 0; i < 5 && i < gq_oh.size(); i++) check("t2_order", 32'(gq_oh[i]), 32'(exp_oh[i]));
    for (int i = 0; i < 4 && i + 1 < gq_cyc.size(); i++) check("t2_spacing", 32'(gq_cyc[i+1] - gq_cyc[i]), 32'd14);
    wait_rsp(2'd0);

    // Requesters 1 and 3 with rr = 2, raised while busy.
    tick;
    do_reset;
    req_a = 64'hc3c3_1e1e_6969_f00f;
    req_b = 64'h2222_4444_8888_1111;
    req_valid = 4'b0010;
    gq_oh.delete(); gq_cyc.delete();
    wait_grants(1);
    tick;
    req_valid = 4'b1010;
    wait_grants(3);
    if (gq_oh.size() >= 3) begin
      check("t3_first", 32'(gq_oh[0]), 32'b0010);
      check("t3_second", 32'(gq_oh[1]), 32'b1000);
      check("t3_third", 32'(gq_oh[2]), 32'b0010);
    end
    tick;
    req_valid = 4'b0000;
    wait_rsp(2'd1);

    // Response stall with pending requests.
    tick;
    rsp_ready = 1'b0;
    req_a = 64'h0000_0000_0000_a5c3;
    req_b = 64'h0000_0000_0000_3f01;
    req_valid = 4'b0001;
    gq_oh.delete(); gq_cyc.delete();
    wait_grants(1);
    tick;
    req_valid = 4'b0101;
    req_a = 64'h0000_7777_0000_0000;
    req_b = 64'h0000_1b1b_0000_0000;
    wait_rsp(2'd0);
    for (int i = 0; i < 20; i++) begin
      sample;
      check("t4_hold_valid", 32'(rsp_valid), 32'd1);
      check("t4_hold_id", 32'(rsp_id), 32'd0);
      check("t4_hold_data", 32'(rsp_data), 32'(exp_result(16'ha5c3, 16'h3f01)));
      check("t4_no_grant", 32'(req_ready), 32'd0);
    end
    tick;
    rsp_ready = 1'b1;
    sample;
    check("t4_accept_valid", 32'(rsp_valid), 32'd1);
    check("t4_accept_no_grant", 32'(req_ready), 32'd0);
    sample;
    check("t4_after_valid", 32'(rsp_valid), 32'd0);
    check("t4_after_grant", 32'(req_ready), 32'b0100);
    tick;
    req_valid = 4'b0000;
    wait_rsp(2'd2);

    // Reset during streaming (k = 4) of a requester 1 op.
    tick;
    req_a = 64'h0000_0000_9999_0000;
    req_b = 64'h0000_0000_6666_0000;
    req_valid = 4'b0010;
    gq_oh.delete(); gq_cyc.delete();
    wait_grants(1);
    tick;
    req_valid = 4'b0000;
    repeat (5) tick;
    reset = 1'b0;
    sample;
    check("t5_adder_rst", 32'(adder_rst), 32'd1);
    tick;
    reset = 1'b1;
    req_valid = 4'b0101;
    req_a = 64'h0000_0d0d_0000_e4b1;
    req_b = 64'h0000_3333_0000_5c27;
    sample;
    check("t5_idle", 32'(busy), 32'd0);
    check("t5_no_rsp", 32'(rsp_valid), 32'd0);
    check("t5_grant0", 32'(req_ready), 32'b0001);
    tick;
    req_valid = 4'b0000;
    wait_rsp(2'd0);

    // Back-to-back ops on requester 1; second must be independent of the first.
    tick;
    req_a = 64'h0000_0000_ffff_0000;
    req_b = 64'h0000_0000_aaaa_0000;
    req_valid = 4'b0010;
    gq_oh.delete(); gq_cyc.delete();
    wait_grants(1);
    tick;
    req_a = 64'h0000_0000_5555_0000;
    req_b = 64'h0;
    wait_grants(2);
    if (gq_cyc.size() >= 2) check("t6_spacing", 32'(gq_cyc[1] - gq_cyc[0]), 32'd14);
    tick;
    req_valid = 4'b0000;
    wait_rsp(2'd1);
    check("t6_rsp_data", 32'(rsp_data), 32'h23938);

    tick;
    tick;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/msdf_add_scheduler.md
# msdf_add_scheduler

Round-robin scheduler that shares one MSDF online adder (2-bit signed-digit, most-significant-digit-first) among NREQ requesters. It accepts a parallel operand pair from the winning requester and clears the adder. It then streams the operand digits MSD-first with a start pulse, flushes with zero digits to cover the adder's online delay, and returns the collected result digits to the requester. It sits between the operand producers and the adder datapath and is the only driver of the adder's inputs.

## Interface
- NREQ, 4, number of requesters (2..16)
- NDIG, 8, operand length in digits
- DELTA, 2, online delay of the adder in cycles
- ZERO_DIG, 2'b00, adder-native encoding of digit value 0, fed during flush
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-low reset (0 = reset)
- req_valid  input  NREQ  per-requester operand valid
- req_ready  output  NREQ  one-hot grant; handshake completes when req_valid[i] and req_ready[i] are both 1
- req_a  input  NREQ*2*NDIG  operand A for requester i at [i*2*NDIG +: 2*NDIG]; digit 0 (MSD) in the top 2 bits
- req_b  input  NREQ*2*NDIG  operand B, same packing
- adder_rst  output  1  active-high reset to the adder
- adder_start  output  1  first-digit marker to the adder
- adder_a, adder_b  output  2  current digit to the adder
- adder_c  input  2  adder output digit
- rsp_valid  output  1  result valid
- rsp_ready  input  1  result accepted
- rsp_id  output  clog2(NREQ)  index of the requester that owns the result
- rsp_data  output  2*(NDIG+DELTA)  result digits, first captured digit in the top 2 bits
- busy  output  1  high in any state other than IDLE

## Operation
- FSM: IDLE -> CLR -> RUN -> RESP -> IDLE.
- **IDLE**
  - req_ready is combinational: it is one-hot on the first requester with req_valid set, searching upward from pointer rr with wrap-around.
  - On a grant: latch req_a, req_b and the index, and set rr = winner+1 mod NREQ. Go to CLR.
  - With no valid request, stay in IDLE; req_ready = 0.
- **CLR** (one cycle): adder_rst = 1. Then go to RUN with k = 0.
- **RUN** (k = 0..NDIG+DELTA, counter width clog2(NDIG+DELTA+1)):
  - adder_start = 1 only when k = 0.
  - adder_a/adder_b = latched digit k while k < NDIG, otherwise ZERO_DIG.
  - For k >= 1, shift adder_c into the result register at the LSB end. This gives exactly NDIG+DELTA captured digits.
  - At k = NDIG+DELTA, capture and go to RESP.
- **RESP**: rsp_valid = 1, with rsp_id and rsp_data held stable. When rsp_ready = 1, go to IDLE.
- Outside RUN: adder_a = adder_b = ZERO_DIG and adder_start = 0.
- adder_rst = (reset == 0) OR (state == CLR). The adder is therefore held cleared during system reset.
- req_ready = 0 outside IDLE. A request is never accepted while an operation is in flight, including in the RESP cycle where rsp_ready is 1.
- Requester operands need only be valid in the grant cycle.

## Timing
- Reset values: state IDLE, rr = 0, k = 0, req_ready = 0, adder_start = 0, adder_a = adder_b = ZERO_DIG, adder_rst = 1 (during reset), rsp_valid = 0, rsp_id = 0, rsp_data = 0, busy = 0.
- Grant in cycle T:
  - CLR occurs at T+1.
  - RUN occurs at T+2 .. T+2+NDIG+DELTA.
  - rsp_valid rises at T+3+NDIG+DELTA (T+13 at defaults).
- Minimum grant-to-grant spacing is NDIG+DELTA+4 cycles (14 at defaults), reached when rsp_ready is already high.
- rsp_ready held low leaves the FSM stalled in RESP indefinitely; no new grants are issued.
- Reset asserted mid-operation: the next state is IDLE. The in-flight result is discarded without rsp_valid, and rr returns to 0.
- A requester dropping req_valid after its grant has no effect.
- req_valid rising during busy is held off until IDLE and then arbitrated normally.

## Test plan
- Single op, defaults, requester 2, A = eight digits of +1, B = all ZERO_DIG:
  - req_ready = 4'b0100 in the grant cycle; adder_rst pulses at T+1; adder_start is high only at T+2.
  - adder_a carries digit +1 for T+2..T+9 and ZERO_DIG for T+10..T+12.
  - rsp_valid at T+13 with rsp_id = 2; rsp_data bit-exactly matches a cycle model of the adder driven by the same sequence.
- All four req_valid held high continuously, rsp_ready = 1: grants go 0, 1, 2, 3, 0, with consecutive grants exactly 14 cycles apart.
- Requesters 1 and 3 valid with rr = 2: grant goes to 3, then rr = 0. The next grant goes to 1.
- rsp_ready held low for 20 cycles after rsp_valid:
  - rsp_valid, rsp_id and rsp_data stay stable; req_ready stays 0 despite pending requests.
  - rsp_ready = 1 drops rsp_valid on the next cycle, and a grant follows in that IDLE cycle.
- reset = 0 at RUN k = 4: the next cycle is IDLE, rsp_valid = 0 and adder_rst = 1 during reset. A subsequent op with requester 0 is granted first and produces a correct result.
- Back-to-back ops with different operands on requester 1: the second result is independent of the first, confirming that the CLR pulse cleared the adder state.
